// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the mmio_aic interrupt-controller front-end.
//   - aic_state_e       : request/service FSM encoding
//   - IVT_* constants   : bit positions and masks inside an IVT entry
//   - *_off functions   : word offsets of the fixed registers behind the IVT block
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } aic_state_e;

  localparam int          IVT_EN_BIT       = 0;
  localparam int          IVT_EDGE_BIT     = 1;
  // Bits [3:2] of an IVT entry do not exist; they are dropped on write.
  localparam logic [31:0] IVT_WMASK        = 32'hFFFF_FFF3;
  localparam logic [31:0] IVT_HANDLER_MASK = 32'hFFFF_FFF0;

  function automatic int pending_off(input int num_irq);
    return num_irq + 1;
  endfunction

  function automatic int eoi_off(input int num_irq);
    return num_irq + 2;
  endfunction

  function automatic int re_off(input int num_irq);
    return num_irq + 3;
  endfunction

  function automatic int ri_off(input int num_irq, input int num_re);
    return num_irq + 3 + num_re;
  endfunction

endpackage

// File: rtl/aic_prio_enc.sv
// aic_prio_enc: lowest-index-first priority encoder.
//   req   : request vector, bit 0 has the highest priority
//   valid : at least one request bit is set
//   idx   : index of the lowest set bit (0 when none)
module aic_prio_enc #(
  parameter int N  = 24,
  parameter int IW = 5
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scanning from the top down lets the lowest set bit be the last to win.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/mmio_aic.sv
// mmio_aic: MMIO front-end splitting CPU bus cycles between a relocatable
// interrupt-controller register window (AICT) and the SRAM port, and driving
// the CPU interrupt request.
//   clk, reset                : clock, synchronous active-high reset
//   stb/ack/addr/dtw/dtr/rw   : CPU bus (stb held until ack)
//   sstb/sack/saddr/sdtw/sdtr/srw : SRAM port (combinational passthrough)
//   irq                       : interrupt lines, synchronous to clk
//   iack                      : CPU took the interrupt (1-cycle pulse)
//   intrq/vec/handler/nmi     : registered interrupt request to the CPU
//   aict_r                    : external read-only registers
//   aict_w                    : bus-writable registers exported to the system
module mmio_aic
  import mmio_pkg::*;
#(
  parameter int          NUM_IRQ         = 24,
  parameter int          NUM_NMI         = 2,
  parameter int          AICT_NUM_RE     = 1,
  parameter int          AICT_NUM_RI     = 1,
  parameter logic [31:0] AICT_RESET_BASE = 32'h0000_FF00
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stb,
  output logic                       ack,
  input  logic [31:0]                addr,
  input  logic [31:0]                dtw,
  output logic [31:0]                dtr,
  input  logic                       rw,
  output logic                       sstb,
  input  logic                       sack,
  output logic [31:0]                saddr,
  output logic [31:0]                sdtw,
  input  logic [31:0]                sdtr,
  output logic                       srw,
  input  logic [NUM_IRQ-1:0]         irq,
  input  logic                       iack,
  output logic                       intrq,
  output logic [4:0]                 vec,
  output logic [31:0]                handler,
  output logic                       nmi,
  input  logic [AICT_NUM_RE*32-1:0]  aict_r,
  output logic [AICT_NUM_RI*32-1:0]  aict_w
);

  localparam int              AICT_LENGTH = NUM_IRQ + 3 + AICT_NUM_RE + AICT_NUM_RI;
  localparam int              IDX_W       = $clog2(AICT_LENGTH);
  localparam logic [IDX_W-1:0] IDX_BASE   = '0;
  localparam logic [IDX_W-1:0] IDX_PEND   = IDX_W'(pending_off(NUM_IRQ));
  localparam logic [IDX_W-1:0] IDX_EOI    = IDX_W'(eoi_off(NUM_IRQ));
  localparam logic [IDX_W-1:0] IDX_RE0    = IDX_W'(re_off(NUM_IRQ));
  localparam logic [IDX_W-1:0] IDX_RI0    = IDX_W'(ri_off(NUM_IRQ, AICT_NUM_RE));
  localparam logic [32:0]     WIN_BYTES   = 33'(AICT_LENGTH * 4);
  localparam logic [5:0]      NMI_LIM     = 6'(NUM_NMI);

  logic [31:0]        base_q;
  logic [31:0]        ivt_q [NUM_IRQ];
  logic [31:0]        ri_q  [AICT_NUM_RI];
  logic [NUM_IRQ-1:0] pending_q, pending_n, irq_prev_q;
  logic               aack_q;
  logic [31:0]        rdata_q, rdata_n;

  aic_state_e  state_q, state_n;
  logic [4:0]  cur_vec_q, cur_vec_n;
  logic        intrq_q, intrq_n;
  logic [4:0]  vec_q, vec_n;
  logic [31:0] handler_q, handler_n;
  logic        nmi_q, nmi_n;

  logic             is_aict, acc, wr, eoi_wr;
  logic [IDX_W-1:0] idx;

  logic [NUM_IRQ-1:0] en_mask, edge_mask, nmi_mask, cand_req;
  logic [NUM_IRQ-1:0] w1c, iack_clr, edge_set;
  logic               cand_valid, cand_nmi;
  logic [4:0]         cand_idx;
  logic [31:0]        cand_handler;

  // 33-bit window compare so a window near the top of memory cannot wrap.
  assign is_aict = ({1'b0, addr} >= {1'b0, base_q}) &&
                   ({1'b0, addr} <  ({1'b0, base_q} + WIN_BYTES));
  assign idx     = IDX_W'((addr - base_q) >> 2);
  assign acc     = stb & is_aict & ~aack_q;
  assign wr      = acc & rw;
  assign eoi_wr  = wr && (idx == IDX_EOI);

  // A BASE write can move the window away from the very address being
  // acknowledged, so the pending acknowledge pulse (and its data) takes
  // precedence over the decode, and the SRAM must not see that cycle.
  assign sstb  = stb & ~is_aict & ~aack_q;
  assign saddr = addr;
  assign sdtw  = dtw;
  assign srw   = rw;
  assign ack   = aack_q | (~is_aict & sack);
  assign dtr   = (is_aict | aack_q) ? rdata_q : sdtr;

  assign intrq   = intrq_q;
  assign vec     = vec_q;
  assign handler = handler_q;
  assign nmi     = nmi_q;

  always_comb begin
    aict_w = '0;
    for (int j = 0; j < AICT_NUM_RI; j++) aict_w[j*32 +: 32] = ri_q[j];
  end

  always_comb begin
    en_mask   = '0;
    edge_mask = '0;
    nmi_mask  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      en_mask[i]   = ivt_q[i][IVT_EN_BIT];
      edge_mask[i] = ivt_q[i][IVT_EDGE_BIT];
      nmi_mask[i]  = (i < NUM_NMI);
    end
    cand_req = pending_q & (en_mask | nmi_mask);
  end

  aic_prio_enc #(.N(NUM_IRQ), .IW(5)) u_prio (
    .req   (cand_req),
    .valid (cand_valid),
    .idx   (cand_idx)
  );

  always_comb begin
    cand_handler = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      if (cand_idx == 5'(i)) cand_handler = ivt_q[i] & IVT_HANDLER_MASK;
    cand_nmi = ({1'b0, cand_idx} < NMI_LIM);
  end

  // Edge lines latch a rising edge until acknowledged (on the vector the CPU
  // was shown) or cleared by W1C; a new edge in the same cycle wins.
  always_comb begin
    w1c       = '0;
    iack_clr  = '0;
    pending_n = '0;
    if (wr && idx == IDX_PEND) w1c = dtw[NUM_IRQ-1:0];
    edge_set = irq & ~irq_prev_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      iack_clr[i]  = iack & intrq_q & (vec_q == 5'(i));
      pending_n[i] = edge_mask[i] ? (edge_set[i] | (pending_q[i] & ~w1c[i] & ~iack_clr[i]))
                                  : irq[i];
    end
  end

  always_comb begin
    rdata_n = '0;
    if (idx == IDX_BASE) rdata_n = base_q;
    for (int i = 0; i < NUM_IRQ; i++)
      if (idx == IDX_W'(i + 1)) rdata_n = ivt_q[i];
    if (idx == IDX_PEND) rdata_n[NUM_IRQ-1:0] = pending_q;
    if (idx == IDX_EOI) begin
      rdata_n[9:8] = state_q;
      rdata_n[4:0] = cur_vec_q;
    end
    for (int j = 0; j < AICT_NUM_RE; j++)
      if (idx == IDX_RE0 + IDX_W'(j)) rdata_n = aict_r[j*32 +: 32];
    for (int j = 0; j < AICT_NUM_RI; j++)
      if (idx == IDX_RI0 + IDX_W'(j)) rdata_n = ri_q[j];
  end

  // Register file, pending bits and the one-cycle acknowledge pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q     <= {AICT_RESET_BASE[31:2], 2'b00};
      for (int i = 0; i < NUM_IRQ; i++) ivt_q[i] <= '0;
      for (int j = 0; j < AICT_NUM_RI; j++) ri_q[j] <= '0;
      pending_q  <= '0;
      irq_prev_q <= '0;
      aack_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      pending_q  <= pending_n;
      irq_prev_q <= irq;
      aack_q     <= acc;
      if (acc) rdata_q <= rdata_n;
      if (wr) begin
        if (idx == IDX_BASE) base_q <= {dtw[31:2], 2'b00};
        for (int i = 0; i < NUM_IRQ; i++)
          if (idx == IDX_W'(i + 1)) ivt_q[i] <= dtw & IVT_WMASK;
        for (int j = 0; j < AICT_NUM_RI; j++)
          if (idx == IDX_RI0 + IDX_W'(j)) ri_q[j] <= dtw;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cur_vec_q <= '0;
      intrq_q   <= 1'b0;
      vec_q     <= '0;
      handler_q <= '0;
      nmi_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      cur_vec_q <= cur_vec_n;
      intrq_q   <= intrq_n;
      vec_q     <= vec_n;
      handler_q <= handler_n;
      nmi_q     <= nmi_n;
    end
  end

  // cur_vec tracks the offered vector while requesting and freezes at iack;
  // in service only an NMI may interrupt a maskable handler, one level deep.
  always_comb begin
    state_n   = state_q;
    cur_vec_n = cur_vec_q;
    intrq_n   = 1'b0;
    vec_n     = vec_q;
    handler_n = handler_q;
    nmi_n     = nmi_q;
    case (state_q)
      ST_IDLE: begin
        if (cand_valid) begin
          state_n   = ST_REQ;
          cur_vec_n = cand_idx;
          intrq_n   = 1'b1;
          vec_n     = cand_idx;
          handler_n = cand_handler;
          nmi_n     = cand_nmi;
        end
      end
      ST_REQ: begin
        if (iack) begin
          state_n = ST_SVC;
        end else if (cand_valid) begin
          cur_vec_n = cand_idx;
          intrq_n   = 1'b1;
          vec_n     = cand_idx;
          handler_n = cand_handler;
          nmi_n     = cand_nmi;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SVC: begin
        if (eoi_wr) begin
          state_n = ST_IDLE;
        end else if (cand_valid && cand_nmi && ({1'b0, cur_vec_q} >= NMI_LIM)) begin
          intrq_n   = 1'b1;
          vec_n     = cand_idx;
          handler_n = cand_handler;
          nmi_n     = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmio_aic.sv
// tb_mmio_aic: directed self-checking bench for mmio_aic (default parameters).
module tb_mmio_aic;

  localparam logic [31:0] A_BASE = 32'h0000_FF00;
  localparam logic [31:0] A_IVT3 = 32'h0000_FF10;
  localparam logic [31:0] A_IVT5 = 32'h0000_FF18;
  localparam logic [31:0] A_IVT6 = 32'h0000_FF1C;
  localparam logic [31:0] A_IVT7 = 32'h0000_FF20;
  localparam logic [31:0] A_PEND = 32'h0000_FF64;
  localparam logic [31:0] A_EOI  = 32'h0000_FF68;
  localparam logic [31:0] A_RE   = 32'h0000_FF6C;
  localparam logic [31:0] A_RI   = 32'h0000_FF70;
  localparam logic [31:0] A_END  = 32'h0000_FF74;

  logic        clk, reset, stb, ack, rw, sstb, sack, srw, iack, intrq, nmi;
  logic [31:0] addr, dtw, dtr, saddr, sdtw, sdtr, handler, aict_r, aict_w;
  logic [23:0] irq;
  logic [4:0]  vec;

  int          vectors, miscompares;
  logic [31:0] rd;
  int          cyc;

  mmio_aic #(
    .NUM_IRQ(24), .NUM_NMI(2), .AICT_NUM_RE(1), .AICT_NUM_RI(1),
    .AICT_RESET_BASE(32'h0000_FF00)
  ) dut (
    .clk(clk), .reset(reset), .stb(stb), .ack(ack), .addr(addr), .dtw(dtw),
    .dtr(dtr), .rw(rw), .sstb(sstb), .sack(sack), .saddr(saddr), .sdtw(sdtw),
    .sdtr(sdtr), .srw(srw), .irq(irq), .iack(iack), .intrq(intrq), .vec(vec),
    .handler(handler), .nmi(nmi), .aict_r(aict_r), .aict_w(aict_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One CPU bus cycle with a bounded wait for ack, followed by an idle cycle.
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] d,
                               input logic w, output logic [31:0] data, output int cycles);
    logic got;
    got = 1'b0; data = '0; cycles = 0;
    stb = 1'b1; addr = a; dtw = d; rw = w;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk); #1;
      cycles++;
      if (ack) begin
        got  = 1'b1;
        data = dtr;
      end
    end
    stb = 1'b0; rw = 1'b0;
    checkOutput({tag, "_ack"}, {31'b0, got}, 32'd1);
    tick(1);
  endtask

  task automatic busWrite(input string tag, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    int c;
    applyStimulus(tag, a, d, 1'b1, dummy, c);
  endtask

  task automatic busRead(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] data;
    int c;
    applyStimulus(tag, a, 32'h0, 1'b0, data, c);
    checkOutput(tag, data, exp);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; stb = 1'b0; addr = '0; dtw = '0; rw = 1'b0;
    sack = 1'b0; sdtr = '0; irq = '0; iack = 1'b0; aict_r = 32'hCAFE_F00D;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_intrq", {31'b0, intrq}, 32'd0);
    checkOutput("rst_vec", {27'b0, vec}, 32'd0);
    checkOutput("rst_handler", handler, 32'd0);
    checkOutput("rst_nmi", {31'b0, nmi}, 32'd0);
    checkOutput("rst_ack", {31'b0, ack}, 32'd0);
    checkOutput("rst_aict_w", aict_w, 32'd0);

    $display("[TB] base read latency and SRAM routing");
    applyStimulus("base_rd", A_BASE, 32'h0, 1'b0, rd, cyc);
    checkOutput("base_rd_lat", cyc, 32'd1);
    checkOutput("base_rd", rd, 32'h0000_FF00);
    stb = 1'b1; addr = A_END; rw = 1'b0; #1;
    checkOutput("end_sstb", {31'b0, sstb}, 32'd1);
    checkOutput("end_ack_low", {31'b0, ack}, 32'd0);
    sack = 1'b1; sdtr = 32'hDEAD_BEEF; #1;
    checkOutput("end_ack_sram", {31'b0, ack}, 32'd1);
    checkOutput("end_dtr_sram", dtr, 32'hDEAD_BEEF);
    sack = 1'b0; addr = A_RI; #1;
    checkOutput("ri_sstb", {31'b0, sstb}, 32'd0);
    stb = 1'b0;
    tick(1);

    $display("[TB] level interrupt on line 5");
    applyStimulus("ivt5_wr", A_IVT5, 32'h0000_1231, 1'b1, rd, cyc);
    checkOutput("ivt5_wr_lat", cyc, 32'd1);
    busRead("ivt5_rd", A_IVT5, 32'h0000_1231);
    busWrite("ivt6_wr", A_IVT6, 32'hFFFF_FFFE);
    busRead("ivt6_rd", A_IVT6, 32'hFFFF_FFF2);
    irq[5] = 1'b1;
    tick(1);
    checkOutput("l5_intrq_1cyc", {31'b0, intrq}, 32'd0);
    tick(1);
    checkOutput("l5_intrq", {31'b0, intrq}, 32'd1);
    checkOutput("l5_vec", {27'b0, vec}, 32'd5);
    checkOutput("l5_handler", handler, 32'h0000_1230);
    checkOutput("l5_nmi", {31'b0, nmi}, 32'd0);
    irq[5] = 1'b0;
    tick(2);
    checkOutput("l5_drop", {31'b0, intrq}, 32'd0);
    busRead("l5_eoi_rd", A_EOI, 32'h0000_0005);

    $display("[TB] edge interrupt on line 7 and service");
    busWrite("ivt7_wr", A_IVT7, 32'h0000_2003);
    irq[7] = 1'b1;
    tick(1);
    irq[7] = 1'b0;
    tick(1);
    checkOutput("e7_intrq", {31'b0, intrq}, 32'd1);
    checkOutput("e7_vec", {27'b0, vec}, 32'd7);
    checkOutput("e7_handler", handler, 32'h0000_2000);
    tick(3);
    checkOutput("e7_hold", {31'b0, intrq}, 32'd1);
    busRead("e7_pend", A_PEND, 32'h0000_0080);
    iack = 1'b1;
    tick(1);
    iack = 1'b0;
    checkOutput("e7_iack_intrq", {31'b0, intrq}, 32'd0);
    busRead("e7_pend_clr", A_PEND, 32'h0000_0000);
    busRead("e7_svc_state", A_EOI, 32'h0000_0207);

    $display("[TB] NMI preemption while servicing line 7");
    irq[1] = 1'b1;
    tick(2);
    checkOutput("nmi_intrq", {31'b0, intrq}, 32'd1);
    checkOutput("nmi_vec", {27'b0, vec}, 32'd1);
    checkOutput("nmi_flag", {31'b0, nmi}, 32'd1);
    irq[1] = 1'b0;
    tick(2);
    checkOutput("nmi_drop", {31'b0, intrq}, 32'd0);
    busWrite("ivt3_wr", A_IVT3, 32'h0000_3001);
    irq[3] = 1'b1;
    tick(3);
    checkOutput("mask_in_svc", {31'b0, intrq}, 32'd0);
    busRead("l3_pend", A_PEND, 32'h0000_0008);
    irq[3] = 1'b0;
    tick(1);
    busWrite("eoi_wr", A_EOI, 32'h0);
    busRead("eoi_idle", A_EOI, 32'h0000_0007);
    checkOutput("eoi_intrq", {31'b0, intrq}, 32'd0);

    $display("[TB] edge set versus W1C in the same cycle");
    irq[7] = 1'b1;
    busWrite("w1c_race", A_PEND, 32'h0000_0080);
    irq[7] = 1'b0;
    busRead("w1c_race_pend", A_PEND, 32'h0000_0080);
    busWrite("w1c_clr", A_PEND, 32'h0000_0080);
    busRead("w1c_clr_pend", A_PEND, 32'h0000_0000);
    tick(2);
    checkOutput("w1c_intrq", {31'b0, intrq}, 32'd0);

    $display("[TB] RI/RE registers");
    busWrite("ri_wr", A_RI, 32'hA5A5_1234);
    checkOutput("ri_aict_w", aict_w, 32'hA5A5_1234);
    busRead("ri_rd", A_RI, 32'hA5A5_1234);
    busRead("re_rd", A_RE, 32'hCAFE_F00D);

    $display("[TB] window relocation");
    busWrite("base_wr", A_BASE, 32'h0001_0003);
    stb = 1'b1; addr = A_BASE; rw = 1'b0; #1;
    checkOutput("old_base_sstb", {31'b0, sstb}, 32'd1);
    stb = 1'b0;
    tick(1);
    busRead("new_base_rd", 32'h0001_0000, 32'h0001_0000);
    busRead("new_ri_rd", 32'h0001_0070, 32'hA5A5_1234);

    $display("[TB] reset during an AICT read");
    stb = 1'b1; addr = 32'h0001_0000; rw = 1'b0;
    tick(1);
    checkOutput("pre_rst_ack", {31'b0, ack}, 32'd1);
    checkOutput("pre_rst_dtr", dtr, 32'h0001_0000);
    reset = 1'b1; addr = A_BASE;
    tick(1);
    checkOutput("rst_mid_ack", {31'b0, ack}, 32'd0);
    checkOutput("rst_mid_aict_w", aict_w, 32'd0);
    checkOutput("rst_mid_intrq", {31'b0, intrq}, 32'd0);
    stb = 1'b0;
    tick(1);
    reset = 1'b0;
    busRead("post_rst_base", A_BASE, 32'h0000_FF00);
    busRead("post_rst_ivt5", A_IVT5, 32'h0000_0000);
    busRead("post_rst_ri", A_RI, 32'h0000_0000);
    busRead("post_rst_eoi", A_EOI, 32'h0000_0000);
    busRead("post_rst_pend", A_PEND, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
